// File: rtl/multiports_vdma_frame_ring.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multiports_vdma_frame_ring : per-channel rotating frame-buffer ring for VDMA
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module multiports_vdma_frame_ring #(
    parameter int          ASIZE       = 29,
    parameter int          CH_NUM      = 8,
    parameter int          BUF_NUM     = 3,
    parameter int unsigned FRAME_STEP  = 2211840,
    parameter int unsigned REGION_BASE = 0
) (
    input  logic              axi_aclk,
    input  logic              axi_rst,
    input  logic [CH_NUM-1:0] ch_enable,
    input  logic [CH_NUM-1:0] wr_frame_start,
    input  logic [CH_NUM-1:0] rd_frame_start,
    output logic [ASIZE-1:0]  wr_baseaddr [CH_NUM],
    output logic [ASIZE-1:0]  rd_baseaddr [CH_NUM],
    output logic [1:0]        wr_idx      [CH_NUM],
    output logic [1:0]        rd_idx      [CH_NUM],
    output logic [15:0]       drop_cnt    [CH_NUM]
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FIRST = 2'd1,
        ST_RUN        = 2'd2
    } state_t;

    localparam logic [1:0] LAST_IDX = 2'(BUF_NUM - 1);

    if ((BUF_NUM != 3 && BUF_NUM != 4) || ASIZE > 32) begin : g_param_check
        $error("multiports_vdma_frame_ring: BUF_NUM must be 3 or 4 and ASIZE <= 32");
    end

    // Ring slot address, formed at 32 bits then truncated to the DDR width.
    function automatic logic [ASIZE-1:0] buf_addr(input int unsigned ch, input logic [1:0] idx);
        logic [31:0] a;
        a = REGION_BASE + (ch * BUF_NUM + 32'(idx)) * FRAME_STEP;
        return a[ASIZE-1:0];
    endfunction

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == LAST_IDX) ? 2'd0 : i + 2'd1;
    endfunction

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        state_t           state;
        logic [1:0]       wr_q, rd_q, done_q;
        logic [1:0]       rd_step, wr_step;
        logic             fresh_q, fresh_step;
        logic [15:0]      drop_q;
        logic [ASIZE-1:0] wr_base_q, rd_base_q;

        // Read event resolves first; the writer then skips the slot the reader now owns.
        always_comb begin
            rd_step    = rd_q;
            fresh_step = fresh_q;
            if (rd_frame_start[g] && fresh_q) begin
                rd_step    = done_q;
                fresh_step = 1'b0;
            end
            wr_step = next_idx(wr_q);
            if (wr_step == rd_step) begin
                wr_step = next_idx(wr_step);
            end
        end

        always_ff @(posedge axi_aclk) begin
            if (axi_rst || !ch_enable[g]) begin
                state     <= ST_IDLE;
                wr_q      <= 2'd0;
                rd_q      <= LAST_IDX;
                done_q    <= LAST_IDX;
                fresh_q   <= 1'b0;
                drop_q    <= 16'd0;
                wr_base_q <= buf_addr(g, 2'd0);
                rd_base_q <= buf_addr(g, LAST_IDX);
            end else begin
                case (state)
                    ST_IDLE: state <= ST_WAIT_FIRST;
                    ST_WAIT_FIRST: begin
                        if (wr_frame_start[g]) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        rd_q      <= rd_step;
                        rd_base_q <= buf_addr(g, rd_step);
                        fresh_q   <= fresh_step;
                        if (wr_frame_start[g]) begin
                            done_q    <= wr_q;
                            fresh_q   <= 1'b1;
                            wr_q      <= wr_step;
                            wr_base_q <= buf_addr(g, wr_step);
                            if (fresh_step && drop_q != 16'hFFFF) begin
                                drop_q <= drop_q + 16'd1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end

        assign wr_baseaddr[g] = wr_base_q;
        assign rd_baseaddr[g] = rd_base_q;
        assign wr_idx[g]      = wr_q;
        assign rd_idx[g]      = rd_q;
        assign drop_cnt[g]    = drop_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_multiports_vdma_frame_ring.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_multiports_vdma_frame_ring : directed + randomized bench with ring model
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_multiports_vdma_frame_ring;

    localparam int          CH   = 2;
    localparam int          BUFN = 3;
    localparam int          ASZ  = 29;
    localparam int unsigned STEP = 2211840;
    localparam int unsigned BASE = 0;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [CH-1:0]  en  = '0;
    logic [CH-1:0]  wrp = '0;
    logic [CH-1:0]  rdp = '0;
    logic [ASZ-1:0] wr_base [CH];
    logic [ASZ-1:0] rd_base [CH];
    logic [1:0]     wr_i    [CH];
    logic [1:0]     rd_i    [CH];
    logic [15:0]    drop    [CH];

    int n_checks = 0;
    int n_pass   = 0;

    // Model: state 0 = idle, 1 = waiting for first write frame, 2 = running.
    int m_st [CH];
    int m_wr [CH];
    int m_rd [CH];
    int m_done [CH];
    int m_fresh [CH];
    int m_drop [CH];

    always #5 clk = ~clk;

    multiports_vdma_frame_ring #(
        .ASIZE(ASZ), .CH_NUM(CH), .BUF_NUM(BUFN), .FRAME_STEP(STEP), .REGION_BASE(BASE)
    ) dut (
        .axi_aclk       (clk),
        .axi_rst        (rst),
        .ch_enable      (en),
        .wr_frame_start (wrp),
        .rd_frame_start (rdp),
        .wr_baseaddr    (wr_base),
        .rd_baseaddr    (rd_base),
        .wr_idx         (wr_i),
        .rd_idx         (rd_i),
        .drop_cnt       (drop)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic longint addr(input int ch, input int i);
        longint a;
        a = longint'(BASE) + longint'(ch * BUFN + i) * longint'(STEP);
        return a % (longint'(1) << ASZ);
    endfunction

    task automatic model_idle(input int c);
        m_st[c] = 0; m_wr[c] = 0; m_rd[c] = BUFN - 1; m_done[c] = BUFN - 1;
        m_fresh[c] = 0; m_drop[c] = 0;
    endtask

    task automatic model_clock();
        int n;
        for (int c = 0; c < CH; c++) begin
            if (rst || !en[c]) begin
                model_idle(c);
            end else if (m_st[c] == 0) begin
                m_st[c] = 1;
            end else if (m_st[c] == 1) begin
                if (wrp[c]) m_st[c] = 2;
            end else begin
                if (rdp[c] && m_fresh[c] == 1) begin
                    m_rd[c] = m_done[c];
                    m_fresh[c] = 0;
                end
                if (wrp[c]) begin
                    if (m_fresh[c] == 1 && m_drop[c] < 65535) m_drop[c]++;
                    m_done[c] = m_wr[c];
                    m_fresh[c] = 1;
                    n = (m_wr[c] + 1) % BUFN;
                    if (n == m_rd[c]) n = (n + 1) % BUFN;
                    m_wr[c] = n;
                end
            end
        end
    endtask

    task automatic check_all(input string ph);
        for (int c = 0; c < CH; c++) begin
            check($sformatf("%s wr_base[%0d]", ph, c), wr_base[c], addr(c, m_wr[c]));
            check($sformatf("%s rd_base[%0d]", ph, c), rd_base[c], addr(c, m_rd[c]));
            check($sformatf("%s wr_idx[%0d]", ph, c), wr_i[c], m_wr[c]);
            check($sformatf("%s rd_idx[%0d]", ph, c), rd_i[c], m_rd[c]);
            check($sformatf("%s drop_cnt[%0d]", ph, c), drop[c], m_drop[c]);
            if (m_st[c] == 2)
                check($sformatf("%s wr_ne_rd[%0d]", ph, c), longint'(wr_i[c] != rd_i[c]), 1);
        end
    endtask

    task automatic step(input string ph, input logic r, input logic [CH-1:0] e,
                        input logic [CH-1:0] w, input logic [CH-1:0] rd);
        rst = r; en = e; wrp = w; rdp = rd;
        @(posedge clk);
        model_clock();
        #1;
        check_all(ph);
    endtask

    initial begin
        for (int c = 0; c < CH; c++) model_idle(c);

        step("reset", 1'b1, 2'b11, 2'b11, 2'b11);
        step("reset", 1'b1, 2'b00, 2'b00, 2'b00);
        check("reset rd_base0 abs", rd_base[0], 4423680);
        check("reset wr_base1 abs", wr_base[1], 6635520);
        check("reset rd_base1 abs", rd_base[1], 11059200);

        // Start-up: enable, first write, second write, then a read.
        step("enable", 1'b0, 2'b01, 2'b00, 2'b00);
        step("wait_rd", 1'b0, 2'b01, 2'b00, 2'b01);
        step("first_wr", 1'b0, 2'b01, 2'b01, 2'b00);
        step("second_wr", 1'b0, 2'b01, 2'b01, 2'b00);
        step("first_rd", 1'b0, 2'b01, 2'b00, 2'b01);
        check("startup rd_base0 abs", rd_base[0], 0);

        for (int k = 0; k < 5; k++) step("drops", 1'b0, 2'b01, 2'b01, 2'b00);
        check("drops abs", drop[0], 4);

        step("simul", 1'b0, 2'b01, 2'b01, 2'b01);
        step("rd_fresh", 1'b0, 2'b01, 2'b00, 2'b01);
        step("rd_repeat", 1'b0, 2'b01, 2'b00, 2'b01);
        step("idle_gap", 1'b0, 2'b01, 2'b00, 2'b00);

        // Disable with a simultaneous write pulse; ch1 runs alongside.
        step("ch1_on", 1'b0, 2'b11, 2'b00, 2'b00);
        step("ch1_wr", 1'b0, 2'b11, 2'b10, 2'b00);
        step("ch1_wr2", 1'b0, 2'b11, 2'b11, 2'b00);
        step("disable", 1'b0, 2'b10, 2'b11, 2'b00);
        step("disabled", 1'b0, 2'b10, 2'b01, 2'b01);

        // Saturation of the drop counter.
        step("sat_en", 1'b0, 2'b11, 2'b00, 2'b00);
        step("sat_wr1", 1'b0, 2'b11, 2'b01, 2'b00);
        step("sat_wr2", 1'b0, 2'b11, 2'b01, 2'b00);
        force dut.g_ch[0].drop_q = 16'hFFFE;
        #1;
        release dut.g_ch[0].drop_q;
        m_drop[0] = 16'hFFFE;
        #1;
        check("sat preload", drop[0], 16'hFFFE);
        for (int k = 0; k < 3; k++) step("sat_drop", 1'b0, 2'b11, 2'b01, 2'b00);
        check("sat abs", drop[0], 16'hFFFF);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            logic          r;
            logic [CH-1:0] e, w, rd;
            r = ($urandom_range(0, 149) == 0);
            for (int c = 0; c < CH; c++) begin
                e[c]  = ($urandom_range(0, 24) != 0);
                w[c]  = ($urandom_range(0, 99) < 40);
                rd[c] = ($urandom_range(0, 99) < 35);
            end
            step("random", r, e, w, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
